wino_tile_transform: RTL and testbench

//  Downstream consumer of the multi-channel line buffer in the Winograd F(2,3) conv path.

---
 rtl/wino_pkg.sv | 16 +
 rtl/wino_bt_1d.sv | 26 ++
 rtl/wino_tile_transform.sv | 127 ++++++++++++
 tb/tb_wino_tile_transform.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/wino_pkg.sv
// Shared constants and FSM state encoding for the Winograd F(2,3) tile transform.
`timescale 1ns/1ps
package wino_pkg;

  localparam int unsigned WINO_N  = 4;   // input tile width
  localparam int unsigned WINO_M  = 2;   // output tile width / stride
  localparam int unsigned WINO_OW = 10;  // signed width of a transformed pixel

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StWait  = 3'd1;
  localparam logic [2:0] StLoad  = 3'd2;
  localparam logic [2:0] StXform = 3'd3;
  localparam logic [2:0] StOut   = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

endpackage

// File: rtl/wino_bt_1d.sv
// Combinational 4-point Winograd F(2,3) input transform B^T*d for one channel.
`timescale 1ns/1ps
module wino_bt_1d
  import wino_pkg::*;
(
  input  logic [4*8-1:0]       d_i,  // pixel0 in MSBs
  output logic [4*WINO_OW-1:0] t_o   // t0 in MSBs, signed fields
);

  logic [WINO_OW-1:0] d0, d1, d2, d3;
  logic [WINO_OW-1:0] t0, t1, t2, t3;

  // Zero-extend unsigned pixels; results fit in 10-bit two's complement.
  assign d0 = {2'b00, d_i[31:24]};
  assign d1 = {2'b00, d_i[23:16]};
  assign d2 = {2'b00, d_i[15:8]};
  assign d3 = {2'b00, d_i[7:0]};

  assign t0 = d0 - d2;
  assign t1 = d1 + d2;
  assign t2 = d2 - d1;
  assign t3 = d1 - d3;

  assign t_o = {t0, t1, t2, t3};

endmodule

// File: rtl/wino_tile_transform.sv
// Snoops line-buffer writes, fetches each resident n-wide tile and emits its B^T transform.
// Optional stall counter port o_stall_cnt is enabled by defining WINO_PERF_CNT_EN.
`timescale 1ns/1ps
module wino_tile_transform
  import wino_pkg::*;
#(
  parameter int unsigned M = 3,
  parameter int unsigned W = 512,
  parameter int unsigned n = 4,
  parameter int unsigned m = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic                   i_pix_valid,
  input  logic [M*n*8-1:0]       i_tile_data,
  output logic                   o_tile_read,
  output logic [M*n*WINO_OW-1:0] o_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [((((W-n)/m+1) > 1) ? $clog2((W-n)/m+1) : 1)-1:0] o_tile_idx,
  output logic                   o_done
`ifdef WINO_PERF_CNT_EN
  ,
  output logic [31:0]            o_stall_cnt
`endif
);

  localparam int unsigned T      = (W - n) / m + 1;
  localparam int unsigned IdxW   = (T > 1) ? $clog2(T) : 1;
  localparam int unsigned CntMax = M * W;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  if (n != WINO_N) begin : gen_bad_n
    $error("wino_tile_transform supports only n == 4");
  end

  logic [2:0]             state_q, state_d;
  logic [CntW-1:0]        wr_cnt_q, wr_cnt_d;
  logic [IdxW-1:0]        tile_idx_q, tile_idx_d;
  logic [M*n*8-1:0]       tile_q;
  logic [M*n*WINO_OW-1:0] data_q;
  logic [M*n*WINO_OW-1:0] xform;
  logic [31:0]            thresh;
  logic                   avail;
  logic                   last_tile;

  for (genvar c = 0; c < M; c++) begin : gen_ch
    wino_bt_1d u_bt (
      .d_i (tile_q[(M-1-c)*n*8 +: n*8]),
      .t_o (xform[(M-1-c)*n*WINO_OW +: n*WINO_OW])
    );
  end

  // Tile k is resident once the last channel row holds pixels up to k*m+n-1.
  assign thresh    = 32'((M - 1) * W + n) + 32'(tile_idx_q) * 32'(m);
  assign avail     = 32'(wr_cnt_q) >= thresh;
  assign last_tile = tile_idx_q == IdxW'(T - 1);

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (i_pix_valid && (wr_cnt_q != CntW'(CntMax))) begin
      wr_cnt_d = wr_cnt_q + CntW'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    tile_idx_d = tile_idx_q;
    case (state_q)
      StIdle:  if (i_start) state_d = StWait;
      StWait:  if (avail) state_d = StLoad;
      StLoad:  state_d = StXform;
      StXform: state_d = StOut;
      StOut: begin
        if (i_ready) begin
          if (last_tile) begin
            state_d = StDone;
          end else begin
            tile_idx_d = tile_idx_q + IdxW'(1);
            state_d    = StWait;
          end
        end
      end
      StDone:  state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      wr_cnt_q   <= '0;
      tile_idx_q <= '0;
      tile_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      tile_idx_q <= tile_idx_d;
      if (state_q == StLoad) tile_q <= i_tile_data;
      if (state_q == StXform) data_q <= xform;
    end
  end

  // Status outputs decode the state register so reset clears them immediately.
  assign o_tile_read = state_q == StLoad;
  assign o_valid     = state_q == StOut;
  assign o_done      = state_q == StDone;
  assign o_data      = data_q;
  assign o_tile_idx  = tile_idx_q;

`ifdef WINO_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_q <= '0;
    end else if (o_valid && !i_ready) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_wino_tile_transform.sv
// Directed self-checking bench for wino_tile_transform with M=3, W=8 (T=3).
`timescale 1ns/1ps
module tb_wino_tile_transform;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         pix_valid;
  logic [95:0]  tile_data;
  logic         tile_read;
  logic [119:0] data;
  logic         valid;
  logic         ready;
  logic [1:0]   tile_idx;
  logic         done;
`ifdef WINO_PERF_CNT_EN
  logic [31:0]  stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int reads  = 0;

  wino_tile_transform #(
    .M (3),
    .W (8),
    .n (4),
    .m (2)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_pix_valid (pix_valid),
    .i_tile_data (tile_data),
    .o_tile_read (tile_read),
    .o_data      (data),
    .o_valid     (valid),
    .i_ready     (ready),
    .o_tile_idx  (tile_idx),
    .o_done      (done)
`ifdef WINO_PERF_CNT_EN
    ,
    .o_stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (tile_read) reads++;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget);
    int k = 0;
    while (!valid && k < budget) begin
      tick();
      k++;
    end
    check_eq("wait_valid", 128'(valid), 128'd1);
  endtask

  function automatic logic [39:0] ch10(input int a, input int b, input int c, input int d);
    return {10'(a), 10'(b), 10'(c), 10'(d)};
  endfunction

  logic [119:0] exp1, exp2, exp3;

  initial begin
    exp1 = {3{ch10(-20, 50, 10, -20)}};
    exp2 = {3{ch10(255, 255, -255, 255)}};
    exp3 = {ch10(-2, 5, 1, -2), ch10(100, 107, 93, -2), ch10(-255, 510, 0, 255)};

    rst_n = 1'b0; start = 1'b0; pix_valid = 1'b0; ready = 1'b0;
    tile_data = {3{32'h0A141E28}};
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", 128'(valid), 128'd0);
    check_eq("rst_read", 128'(tile_read), 128'd0);
    check_eq("rst_done", 128'(done), 128'd0);
    check_eq("rst_idx", 128'(tile_idx), 128'd0);
    check_eq("rst_data", 128'(data), 128'd0);
    rst_n = 1'b1;
    tick();

    // First tile needs 20 writes: two full rows plus four pixels.
    start = 1'b1; tick(); start = 1'b0;
    pix_valid = 1'b1;
    for (int i = 0; i < 19; i++) begin
      tick();
      check_eq("early_read", 128'(tile_read), 128'd0);
    end
    tick();
    pix_valid = 1'b0;
    check_eq("read_wait_cycle", 128'(tile_read), 128'd0);
    tick();
    check_eq("read_pulse", 128'(tile_read), 128'd1);
    check_eq("load_valid", 128'(valid), 128'd0);
    tick();
    check_eq("xform_read", 128'(tile_read), 128'd0);
    check_eq("xform_valid", 128'(valid), 128'd0);
    tick();
    check_eq("valid_lat", 128'(valid), 128'd1);
    check_eq("data_ramp", 128'(data), 128'(exp1));

    for (int k = 0; k < 5; k++) begin
      check_eq("hold_valid", 128'(valid), 128'd1);
      check_eq("hold_data", 128'(data), 128'(exp1));
      check_eq("hold_read", 128'(tile_read), 128'd0);
      tick();
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check_eq("idx_after_hs", 128'(tile_idx), 128'd1);
    check_eq("valid_after_hs", 128'(valid), 128'd0);
`ifdef WINO_PERF_CNT_EN
    check_eq("stall_cnt", 128'(stall_cnt), 128'd5);
`endif

    // Second tile: two more writes.
    tile_data = {3{32'hFFFF0000}};
    ready = 1'b1;
    pix_valid = 1'b1;
    repeat (2) tick();
    pix_valid = 1'b0;
    wait_valid(10);
    check_eq("data_edge", 128'(data), 128'(exp2));
    tick();
    check_eq("idx_tile2", 128'(tile_idx), 128'd2);

    // Third tile with distinct per-channel data to exercise packing.
    tile_data = {32'h01020304, 32'hC8076409, 32'h00FFFF00};
    pix_valid = 1'b1;
    repeat (2) tick();
    pix_valid = 1'b0;
    wait_valid(10);
    check_eq("data_mixed", 128'(data), 128'(exp3));
    begin
      int k = 0;
      while (!done && k < 10) begin
        tick();
        k++;
      end
    end
    check_eq("done", 128'(done), 128'd1);
    pix_valid = 1'b1;
    repeat (3) tick();
    pix_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (2) tick();
    check_eq("done_sticky", 128'(done), 128'd1);
    check_eq("done_idx", 128'(tile_idx), 128'd2);
    check_eq("done_read", 128'(tile_read), 128'd0);
    check_eq("read_count", 128'(reads), 128'd3);

    // Asynchronous reset in the middle of OUT.
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    start = 1'b1; tick(); start = 1'b0;
    ready = 1'b0;
    pix_valid = 1'b1;
    repeat (20) tick();
    pix_valid = 1'b0;
    wait_valid(10);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", 128'(valid), 128'd0);
    check_eq("arst_read", 128'(tile_read), 128'd0);
    check_eq("arst_idx", 128'(tile_idx), 128'd0);
    check_eq("arst_data", 128'(data), 128'd0);
    tick();
    rst_n = 1'b1;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    pix_valid = 1'b1;
    repeat (19) tick();
    pix_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("wrcnt_cleared", 128'(tile_read), 128'd0);
    end
    pix_valid = 1'b1; tick(); pix_valid = 1'b0;
    begin
      int k = 0;
      while (!tile_read && k < 5) begin
        tick();
        k++;
      end
    end
    check_eq("read_after_20", 128'(tile_read), 128'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
